// File: rtl/i2s_target_transceiver.sv
// i2s_target_transceiver
//   I2S target port. The external master owns sclk and lrck; this block
//   oversamples them in the clk domain, deserialises sdin into stereo
//   samples and serialises a stereo pair onto sdout.
// Ports:
//   clk, resetN           system clock (>= 8x sclk), async active-low reset
//   sclk, lrck, sdin      I2S inputs from the master (asynchronous to clk)
//   sdout                 I2S serial output, updated after sclk falling edges
//   rxLeft/rxRight        last complete received pair, rxValid pulses with it
//   txLeft/txRight        pair to transmit, loaded on txValid when txReady
//   underrun              left slot started with nothing to send
//   slotError             slot ended before SerialDataWidth bits arrived
module i2s_target_transceiver #(
    parameter int DataWidth = 12
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 sclk,
    input  logic                 lrck,
    input  logic                 sdin,
    output logic                 sdout,
    output logic [DataWidth-1:0] rxLeft,
    output logic [DataWidth-1:0] rxRight,
    output logic                 rxValid,
    input  logic [DataWidth-1:0] txLeft,
    input  logic [DataWidth-1:0] txRight,
    input  logic                 txValid,
    output logic                 txReady,
    output logic                 underrun,
    output logic                 slotError
);
    localparam int SW = 24;  // serial bits per slot

    // ------------------------------------------------------------------
    // Input conditioning: [0],[1] synchronizer, [2] previous value.
    // All three lines share the same depth so their alignment survives.
    // ------------------------------------------------------------------
    logic [2:0] sclk_p, lrck_p, sdin_p;
    logic [1:0] warm_cnt;
    logic       warm_done;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sclk_p   <= '0;
            lrck_p   <= '0;
            sdin_p   <= '0;
            warm_cnt <= '0;
        end else begin
            sclk_p <= {sclk_p[1:0], sclk};
            lrck_p <= {lrck_p[1:0], lrck};
            sdin_p <= {sdin_p[1:0], sdin};
            if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // Edges are suppressed until the pipeline has filled with real line
    // levels, so a line that was already high at reset release does not
    // look like a fresh transition.
    assign warm_done = (warm_cnt == 2'd3);

    logic sclk_rise, sclk_fall, lrck_edge, lrck_now, sdin_now;
    assign sclk_rise = warm_done &  sclk_p[1] & ~sclk_p[2];
    assign sclk_fall = warm_done & ~sclk_p[1] &  sclk_p[2];
    assign lrck_edge = warm_done & (lrck_p[1] ^ lrck_p[2]);
    assign lrck_now  = lrck_p[1];
    assign sdin_now  = sdin_p[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, PAD} rx_state_t;

    rx_state_t          rx_state;
    logic               slot_id;
    logic [4:0]         bit_cnt;
    logic [SW-1:0]      shift;
    logic [SW-1:0]      shift_nxt;
    logic [DataWidth-1:0] left_stage, right_stage;
    logic               left_ok;   // complete left slot seen in this frame
    logic               copy_go;

    assign shift_nxt = {shift[SW-2:0], sdin_now};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rx_state    <= IDLE;
            slot_id     <= 1'b0;
            bit_cnt     <= '0;
            shift       <= '0;
            left_stage  <= '0;
            right_stage <= '0;
            left_ok     <= 1'b0;
            copy_go     <= 1'b0;
            rxLeft      <= '0;
            rxRight     <= '0;
            rxValid     <= 1'b0;
            slotError   <= 1'b0;
        end else begin
            slotError <= 1'b0;
            rxValid   <= 1'b0;
            copy_go   <= 1'b0;

            // Publish the pair one clk after the right slot completed.
            if (copy_go) begin
                rxLeft  <= left_stage;
                rxRight <= right_stage;
                rxValid <= 1'b1;
            end

            if (lrck_edge) begin
                slot_id  <= lrck_now;
                rx_state <= ALIGN;
                if (rx_state == ALIGN || rx_state == SHIFT) begin
                    slotError <= 1'b1;
                    left_ok   <= 1'b0;
                end
                // A new frame starts at the left slot.
                if (!lrck_now) left_ok <= 1'b0;
            end else begin
                case (rx_state)
                    ALIGN: begin
                        // I2S one-bit delay: first rise belongs to no word.
                        if (sclk_rise) begin
                            rx_state <= SHIFT;
                            bit_cnt  <= '0;
                            shift    <= '0;
                        end
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            shift   <= shift_nxt;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'(SW - 1)) begin
                                rx_state <= PAD;
                                if (!slot_id) begin
                                    left_stage <= shift_nxt[SW-1 -: DataWidth];
                                    left_ok    <= 1'b1;
                                end else begin
                                    right_stage <= shift_nxt[SW-1 -: DataWidth];
                                    copy_go     <= left_ok;
                                    left_ok     <= 1'b0;
                                end
                            end
                        end
                    end
                    default: ;  // IDLE and PAD only react to lrck_edge
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [DataWidth-1:0] hold_l, hold_r;
    logic [DataWidth-1:0] pair_l, pair_r;
    logic [DataWidth-1:0] pair_l_nxt, pair_r_nxt;
    logic [SW-1:0]        tx_word;   // MSB is the next bit to drive
    logic                 tx_active;
    logic                 left_start;

    assign left_start = lrck_edge & ~lrck_now;

    // Pair register contents as of the left-slot start; the left word is
    // launched from this value in the same clk.
    always_comb begin
        pair_l_nxt = pair_l;
        pair_r_nxt = pair_r;
        if (left_start) begin
            if (!txReady) begin
                pair_l_nxt = hold_l;
                pair_r_nxt = hold_r;
            end else if (txValid) begin
                pair_l_nxt = txLeft;
                pair_r_nxt = txRight;
            end else begin
                pair_l_nxt = '0;
                pair_r_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_l    <= '0;
            hold_r    <= '0;
            pair_l    <= '0;
            pair_r    <= '0;
            txReady   <= 1'b1;
            underrun  <= 1'b0;
            tx_word   <= '0;
            tx_active <= 1'b0;
            sdout     <= 1'b0;
        end else begin
            underrun <= 1'b0;
            pair_l   <= pair_l_nxt;
            pair_r   <= pair_r_nxt;

            if (left_start) begin
                if (!txReady)      txReady  <= 1'b1;
                else if (!txValid) underrun <= 1'b1;
            end else if (txValid && txReady) begin
                hold_l  <= txLeft;
                hold_r  <= txRight;
                txReady <= 1'b0;
            end

            // Left-justify the slot word; shifting left zero-fills so bits
            // past the sample and past the slot width come out as 0.
            if (lrck_edge) begin
                tx_word   <= SW'(lrck_now ? pair_r_nxt : pair_l_nxt) << (SW - DataWidth);
                tx_active <= 1'b1;
            end else if (sclk_fall && tx_active) begin
                sdout   <= tx_word[SW-1];
                tx_word <= {tx_word[SW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_target_transceiver.sv
// Testbench for i2s_target_transceiver: acts as the I2S master, drives
// frames of 64 sclk at clk = 16x sclk, and checks received pairs, the
// serial output and the status pulses against a simple frame-level model.
module tb_i2s_target_transceiver;
    localparam int DW = 12;

    logic          clk, resetN, sclk, lrck, sdin, sdout;
    logic [DW-1:0] rxLeft, rxRight, txLeft, txRight;
    logic          rxValid, txValid, txReady, underrun, slotError;

    i2s_target_transceiver #(.DataWidth(DW)) dut (
        .clk(clk), .resetN(resetN), .sclk(sclk), .lrck(lrck), .sdin(sdin),
        .sdout(sdout), .rxLeft(rxLeft), .rxRight(rxRight), .rxValid(rxValid),
        .txLeft(txLeft), .txRight(txRight), .txValid(txValid),
        .txReady(txReady), .underrun(underrun), .slotError(slotError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pulse monitors, counted per frame.
    int          n_rxv, n_und, n_serr;
    logic [DW-1:0] cap_l, cap_r;
    always @(negedge clk) begin
        if (resetN) begin
            if (rxValid) begin
                n_rxv++;
                cap_l = rxLeft;
                cap_r = rxRight;
            end
            if (underrun)  n_und++;
            if (slotError) n_serr++;
        end
    end

    // Transmit model: one-deep holding register, emptied at each frame.
    bit            m_full;
    logic [DW-1:0] m_l, m_r;

    task automatic load(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk);
        txValid = 1'b1; txLeft = l; txRight = r;
        @(negedge clk);
        txValid = 1'b0;
        if (!m_full) begin m_full = 1; m_l = l; m_r = r; end
    endtask

    task automatic load2(input logic [DW-1:0] l0, input logic [DW-1:0] r0,
                         input logic [DW-1:0] l1, input logic [DW-1:0] r1);
        @(negedge clk);
        txValid = 1'b1; txLeft = l0; txRight = r0;
        @(negedge clk);
        txLeft = l1; txRight = r1;
        @(negedge clk);
        txValid = 1'b0;
        if (!m_full) begin m_full = 1; m_l = l0; m_r = r0; end
    endtask

    // One slot as master: lrck and data change on the falling edge, the
    // target's output is sampled on the rising edge.
    task automatic slot(input bit id, input logic [23:0] w, input int len,
                        output logic [23:0] obs);
        obs = '0;
        for (int k = 0; k < len; k++) begin
            sclk = 1'b0;
            if (k == 0) lrck = id;
            if (k >= 1 && k <= 24) sdin = w[24-k];
            else                   sdin = 1'b0;
            #80;
            sclk = 1'b1;
            if (k >= 1 && k <= 24) obs[24-k] = sdout;
            #80;
        end
    endtask

    task automatic frame_check(input string tag, input logic [23:0] lw, input logic [23:0] rw,
                               input int llen, input bit exp_valid,
                               input logic [DW-1:0] exp_l, input logic [DW-1:0] exp_r,
                               input bit exp_serr, input bit after_reset);
        logic [23:0] ol, orr, mask, ones;
        logic [DW-1:0] etl, etr;
        bit eund;
        int nb;
        if (after_reset) begin
            // The left-slot start was never seen: nothing is sent or flagged.
            eund = 0; etl = '0; etr = '0;
        end else begin
            eund = !m_full;
            etl  = m_full ? m_l : '0;
            etr  = m_full ? m_r : '0;
            m_full = 0;
        end
        @(negedge clk); #2;
        n_rxv = 0; n_und = 0; n_serr = 0;
        slot(1'b0, lw, llen, ol);
        slot(1'b1, rw, 32, orr);
        repeat (20) @(negedge clk);
        chk({tag, "_rxvalid_cnt"}, n_rxv, exp_valid ? 1 : 0);
        if (exp_valid) begin
            chk({tag, "_rxleft"},  cap_l, exp_l);
            chk({tag, "_rxright"}, cap_r, exp_r);
        end
        chk({tag, "_sloterr_cnt"}, n_serr, exp_serr ? 1 : 0);
        chk({tag, "_underrun_cnt"}, n_und, eund ? 1 : 0);
        nb   = (llen - 1 < 24) ? llen - 1 : 24;
        ones = '1;
        mask = ones << (24 - nb);
        chk({tag, "_tx_left"},  ol & mask, {etl, 12'h000} & mask);
        chk({tag, "_tx_right"}, orr, {etr, 12'h000});
        chk({tag, "_txready"},  txReady, !m_full);
    endtask

    typedef struct {
        logic [23:0]   lw, rw;
        bit            ld;
        logic [DW-1:0] tl, tr;
        int            llen;
        bit            exp_valid;
        logic [DW-1:0] exp_l, exp_r;
        bit            exp_serr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; sclk = 1'b1; lrck = 1'b1; sdin = 1'b0;
        txValid = 1'b0; txLeft = '0; txRight = '0;
        m_full = 0; m_l = '0; m_r = '0;
        n_rxv = 0; n_und = 0; n_serr = 0; cap_l = '0; cap_r = '0;

        vecs[0] = '{24'hABC000, 24'h123000, 0, 12'h000, 12'h000, 32, 1, 12'hABC, 12'h123, 0};
        vecs[1] = '{24'h555555, 24'hAAAAAA, 1, 12'h7FF, 12'h800, 32, 1, 12'h555, 12'hAAA, 0};
        vecs[2] = '{24'hFFF000, 24'h000FFF, 0, 12'h000, 12'h000, 32, 1, 12'hFFF, 12'h000, 0};
        vecs[3] = '{24'h123456, 24'h654321, 1, 12'h0A5, 12'hF5A, 11, 0, 12'h000, 12'h000, 1};
        vecs[4] = '{24'h800001, 24'h7FFFFF, 1, 12'h123, 12'h456, 32, 1, 12'h800, 12'h7FF, 0};

        repeat (4) @(negedge clk);
        chk("rst_sdout",   sdout, 0);
        chk("rst_rxleft",  rxLeft, 0);
        chk("rst_rxright", rxRight, 0);
        chk("rst_rxvalid", rxValid, 0);
        chk("rst_txready", txReady, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_sloterr", slotError, 0);
        resetN = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].ld) begin
                load(vecs[i].tl, vecs[i].tr);
                chk($sformatf("vec%0d_txready_loaded", i), txReady, 0);
            end
            frame_check($sformatf("vec%0d", i), vecs[i].lw, vecs[i].rw, vecs[i].llen,
                        vecs[i].exp_valid, vecs[i].exp_l, vecs[i].exp_r,
                        vecs[i].exp_serr, 0);
        end

        // Back-to-back txValid: only the first pair is kept.
        load2(12'h321, 12'h654, 12'h111, 12'h222);
        frame_check("b2b", 24'h0F0F0F, 24'hF0F0F0, 32, 1, 12'h0F0, 12'hF0F, 0, 0);

        // Randomised frames against the model.
        for (int i = 0; i < 8; i++) begin
            logic [23:0] lw, rw;
            lw = 24'($urandom);
            rw = 24'($urandom);
            if ($urandom_range(0, 1) == 1) load(DW'($urandom), DW'($urandom));
            frame_check($sformatf("rnd%0d", i), lw, rw, 32, 1, lw[23:12], rw[23:12], 0, 0);
        end

        // Asynchronous reset in the middle of a left slot, away from clk edges.
        begin
            logic [23:0] junk;
            @(negedge clk); #2;
            slot(1'b0, 24'hFFFFFF, 13, junk);
            load(12'hAAA, 12'h555);
            #4;
            resetN = 1'b0;
            #1;
            chk("arst_sdout",    sdout, 0);
            chk("arst_rxleft",   rxLeft, 0);
            chk("arst_rxright",  rxRight, 0);
            chk("arst_rxvalid",  rxValid, 0);
            chk("arst_txready",  txReady, 1);
            chk("arst_underrun", underrun, 0);
            chk("arst_sloterr",  slotError, 0);
            m_full = 0;
            repeat (3) @(negedge clk);
            resetN = 1'b1;
            repeat (6) @(negedge clk);
        end
        // lrck was already low at release, so this frame's left slot is not
        // seen; the following full frame is the first to decode.
        frame_check("post_rst_a", 24'h456000, 24'h789000, 32, 0, 12'h000, 12'h000, 0, 1);
        frame_check("post_rst_b", 24'h9AB000, 24'hCDE000, 32, 1, 12'h9AB, 12'hCDE, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
